// File: rtl/ss_param.sv
// Serial selector: captures N words of W bits, then scans them to report
// the index and value of the maximum (Mode=0) or minimum (Mode=1) entry.
module ss_param #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 6,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          Start,
    input  logic          Mode,
    input  logic          inValid,
    input  logic [W-1:0]  inBus,
    output logic          Ready,
    output logic          Busy,
    output logic [IW-1:0] outBus,
    output logic [W-1:0]  outVal
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SEARCH = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [IW-1:0] last_idx = IW'(N - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic          mode_q, mode_d;
    logic [IW-1:0] best_idx_q, best_idx_d;
    logic [W-1:0]  best_val_q, best_val_d;
    logic          ready_d, busy_d;
    logic [IW-1:0] out_bus_d;
    logic [W-1:0]  out_val_d;
    logic          wr_en;
    logic [W-1:0]  cand;
    logic          better;

    logic [W-1:0]  entry [N];

    // Register file has no reset; its contents are only read after a full load.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            entry[cnt_q] <= inBus;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mode_q     <= 1'b0;
            best_idx_q <= '0;
            best_val_q <= '0;
            Ready      <= 1'b0;
            Busy       <= 1'b0;
            outBus     <= '0;
            outVal     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            best_idx_q <= best_idx_d;
            best_val_q <= best_val_d;
            Ready      <= ready_d;
            Busy       <= busy_d;
            outBus     <= out_bus_d;
            outVal     <= out_val_d;
        end
    end

    // Next-state, datapath and registered-output next values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        best_idx_d = best_idx_q;
        best_val_d = best_val_q;
        out_bus_d  = outBus;
        out_val_d  = outVal;
        wr_en      = 1'b0;
        cand       = entry[cnt_q];
        better     = mode_q ? (cand < best_val_q) : (cand > best_val_q);

        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    state_d = LOAD;
                    mode_d  = Mode;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (inValid) begin
                    wr_en = 1'b1;
                    if (cnt_q == '0) begin
                        best_val_d = inBus;
                        best_idx_d = '0;
                    end
                    if (cnt_q == last_idx) begin
                        state_d = SEARCH;
                        cnt_d   = IW'(1);
                    end else begin
                        cnt_d = cnt_q + IW'(1);
                    end
                end
            end
            SEARCH: begin
                // Strict compare keeps the lowest index on ties.
                if (better) begin
                    best_val_d = cand;
                    best_idx_d = cnt_q;
                end
                if (cnt_q == last_idx) begin
                    state_d   = DONE;
                    cnt_d     = '0;
                    out_bus_d = best_idx_d;
                    out_val_d = best_val_d;
                end else begin
                    cnt_d = cnt_q + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == DONE);
        busy_d  = (state_d == LOAD) || (state_d == SEARCH);
    end

endmodule

// File: tb/tb_ss_param.sv
// Scoreboard bench for ss_param: an N=8/W=6 instance and an N=5/W=4 instance.
module tb_ss_param;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       a_start, a_mode, a_valid;
    logic [5:0] a_bus;
    logic       a_ready, a_busy;
    logic [2:0] a_out;
    logic [5:0] a_val;

    logic       b_start, b_mode, b_valid;
    logic [3:0] b_bus;
    logic       b_ready, b_busy;
    logic [2:0] b_out;
    logic [3:0] b_val;

    ss_param #(.N(8), .W(6)) dut_a (
        .clk(clk), .rst(rst), .Start(a_start), .Mode(a_mode), .inValid(a_valid),
        .inBus(a_bus), .Ready(a_ready), .Busy(a_busy), .outBus(a_out), .outVal(a_val)
    );

    ss_param #(.N(5), .W(4)) dut_b (
        .clk(clk), .rst(rst), .Start(b_start), .Mode(b_mode), .inValid(b_valid),
        .inBus(b_bus), .Ready(b_ready), .Busy(b_busy), .outBus(b_out), .outVal(b_val)
    );

    typedef struct {
        int idx;
        int val;
        int tot;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit b, input logic st, input logic md, input logic vl,
                         input logic [5:0] d);
        if (b) begin
            b_start = st; b_mode = md; b_valid = vl; b_bus = d[3:0];
        end else begin
            a_start = st; a_mode = md; a_valid = vl; a_bus = d;
        end
    endtask

    function automatic logic [31:0] o_rdy(input bit b);
        return b ? 32'(b_ready) : 32'(a_ready);
    endfunction
    function automatic logic [31:0] o_busy(input bit b);
        return b ? 32'(b_busy) : 32'(a_busy);
    endfunction
    function automatic logic [31:0] o_idx(input bit b);
        return b ? 32'(b_out) : 32'(a_out);
    endfunction
    function automatic logic [31:0] o_val(input bit b);
        return b ? 32'(b_val) : 32'(a_val);
    endfunction

    // One complete run; abort_at >= 0 resets the design that many edges into SEARCH.
    task automatic run(input bit b, input logic md, input int n, input int w[8],
                       input int gap_at, input int gap_len, input int abort_at);
        int          best, bi, s, last;
        logic [31:0] pi, pv;
        bit          got;
        exp_t        e;

        best = w[0];
        bi   = 0;
        for (int i = 1; i < n; i++) begin
            if (md ? (w[i] < best) : (w[i] > best)) begin
                best = w[i];
                bi   = i;
            end
        end
        sb.push_back('{bi, best, 2 * n - 1 + gap_len});

        pi = o_idx(b);
        pv = o_val(b);
        last = 0;

        drive(b, 1'b1, md, 1'b0, 6'd0);
        @(posedge clk); #1;
        s = cyc;
        drive(b, 1'b0, md, 1'b0, 6'd0);
        check("start_ready", o_rdy(b), 0);
        check("start_busy", o_busy(b), 1);
        check("start_hold_idx", o_idx(b), pi);
        check("start_hold_val", o_val(b), pv);

        for (int i = 0; i < n; i++) begin
            drive(b, 1'b0, md, 1'b1, 6'(w[i]));
            @(posedge clk); #1;
            if (i == n - 1) last = cyc;
            check("load_busy", o_busy(b), 1);
            check("load_hold_idx", o_idx(b), pi);
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    drive(b, (g % 2) == 0, ~md, 1'b0, 6'h2a);
                    @(posedge clk); #1;
                    check("gap_busy", o_busy(b), 1);
                    check("gap_ready", o_rdy(b), 0);
                end
            end
        end
        drive(b, 1'b0, md, 1'b0, 6'd0);

        if (abort_at >= 0) begin
            repeat (abort_at) @(posedge clk);
            #3;
            rst = 1'b0;
            #1;
            check("abort_ready", o_rdy(b), 0);
            check("abort_busy", o_busy(b), 0);
            check("abort_idx", o_idx(b), 0);
            check("abort_val", o_val(b), 0);
            e = sb.pop_front();
            @(negedge clk);
            rst = 1'b1;
            @(posedge clk); #1;
            check("abort_idle_busy", o_busy(b), 0);
            return;
        end

        got = 1'b0;
        for (int k = 0; k < 64; k++) begin
            drive(b, 1'b0, ~md, k[0], 6'h3f);
            @(posedge clk); #1;
            if (o_rdy(b) == 1) begin
                got = 1'b1;
                break;
            end
            check("search_busy", o_busy(b), 1);
            check("search_hold_val", o_val(b), pv);
        end
        drive(b, 1'b0, md, 1'b0, 6'd0);
        check("ready_seen", 32'(got), 1);
        e = sb.pop_front();
        if (got) begin
            check("result_idx", o_idx(b), e.idx);
            check("result_val", o_val(b), e.val);
            check("lat_last_word", cyc - last, n - 1);
            check("lat_start", cyc - s, e.tot);
            check("done_busy", o_busy(b), 0);
            @(posedge clk); #1;
            check("done_ready_held", o_rdy(b), 1);
            check("done_idx_held", o_idx(b), e.idx);
            check("done_val_held", o_val(b), e.val);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_ready", o_rdy(0), 0);
        check("rst_a_busy", o_busy(0), 0);
        check("rst_a_idx", o_idx(0), 0);
        check("rst_a_val", o_val(0), 0);
        check("rst_b_ready", o_rdy(1), 0);
        check("rst_b_busy", o_busy(1), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        run(1'b0, 1'b0, 8, '{12, 45, 3, 45, 7, 0, 33, 0}, -1, 0, -1);
        run(1'b0, 1'b1, 8, '{63, 63, 63, 63, 63, 63, 63, 63}, -1, 0, -1);
        run(1'b0, 1'b1, 8, '{12, 45, 3, 45, 7, 0, 33, 0}, -1, 0, -1);
        run(1'b0, 1'b0, 8, '{12, 45, 3, 45, 7, 0, 33, 0}, 2, 3, -1);
        run(1'b0, 1'b0, 8, '{12, 45, 3, 45, 7, 0, 33, 0}, -1, 0, 3);
        run(1'b0, 1'b0, 8, '{5, 9, 60, 2, 60, 1, 0, 17}, -1, 0, -1);
        run(1'b0, 1'b1, 8, '{40, 41, 39, 50, 39, 63, 44, 38}, -1, 0, -1);
        run(1'b1, 1'b0, 5, '{9, 2, 15, 15, 1, 0, 0, 0}, -1, 0, -1);
        run(1'b1, 1'b1, 5, '{9, 2, 15, 15, 1, 0, 0, 0}, 1, 2, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
